// File: rtl/game_physics_ctrl.sv
// Frame-rate game engine: bird physics, pipe scrolling, hole placement, scoring, collision and
// the IDLE/PLAY/DEAD flow. All outputs are registered; frame updates happen on the v_sync rising edge.
module game_physics_ctrl #(
    parameter int BIRD_X      = 100,
    parameter int BIRD_SZ     = 8,
    parameter int BIRD_Y0     = 236,
    parameter int FLOOR_Y     = 472,
    parameter int PIPE_W      = 40,
    parameter int HOLE_H      = 100,
    parameter int HOLE_MIN    = 40,
    parameter int PIPE_SPAWN  = 640,
    parameter int PIPE_SPEED  = 2,
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = 6,
    parameter int MAX_FALL    = 8,
    parameter int DEAD_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       v_sync,
    input  logic       button,
    output logic [8:0] bird_pos,
    output logic [8:0] hole_pos,
    output logic [9:0] pipe_pos,
    output logic [7:0] score,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DEAD = 2'b10
    } state_t;

    localparam int DCW = $clog2(DEAD_FRAMES + 1);

    localparam logic signed [5:0] VEL_FLAP = 6'(-FLAP_VEL);
    localparam logic signed [5:0] VEL_GRAV = 6'(GRAVITY);
    localparam logic signed [5:0] VEL_MAX  = 6'(MAX_FALL);
    localparam logic [11:0]       BX       = 12'(BIRD_X);
    localparam logic [11:0]       BSZ      = 12'(BIRD_SZ);
    localparam logic [11:0]       PW       = 12'(PIPE_W);
    localparam logic [11:0]       HH       = 12'(HOLE_H);
    localparam logic [9:0]        SPAWN    = 10'(PIPE_SPAWN);
    localparam logic [9:0]        SPEED    = 10'(PIPE_SPEED);
    localparam logic [8:0]        Y0       = 9'(BIRD_Y0);
    localparam logic [8:0]        YF       = 9'(FLOOR_Y);
    localparam logic [8:0]        HMIN     = 9'(HOLE_MIN);
    localparam logic [8:0]        HOLE_RST = 9'd190;
    localparam logic [DCW-1:0]    DC_MAX   = DCW'(DEAD_FRAMES);
    localparam logic [DCW-1:0]    DC_ONE   = DCW'(1);

    state_t            st;
    logic signed [5:0] vel;
    logic              flap_pend;
    logic              passed;
    logic [DCW-1:0]    dead_cnt;
    logic [7:0]        lfsr;
    logic              vs_q;
    logic              btn_q;

    logic              tick;
    logic              btn_rise;
    logic              lfsr_fb;

    assign tick     = v_sync & ~vs_q;
    assign btn_rise = button & ~btn_q;
    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign state    = st;

    // Next-frame candidates for PLAY; only committed on a tick.
    logic              flap;
    logic signed [5:0] vel_inc;
    logic signed [5:0] vel_n;
    logic [10:0]       by_raw;
    logic              floor_hit;
    logic [8:0]        by_c;
    logic              respawn;
    logic [9:0]        pipe_n;
    logic [8:0]        hole_n;
    logic              passed_n;
    logic [11:0]       pipe12;
    logic [11:0]       by12;
    logic [11:0]       hole12;
    logic              pass_now;
    logic              x_ovl;
    logic              hit;
    logic              die;

    // NOTE: every signal gets a value on every path through this block, otherwise a latch is inferred.
    always_comb begin
        flap      = flap_pend | btn_rise;
        vel_inc   = vel + VEL_GRAV;
        vel_n     = flap ? VEL_FLAP : ((vel_inc > VEL_MAX) ? VEL_MAX : vel_inc);

        // by_raw is two's complement: bit 10 set means the bird went above row 0.
        by_raw    = {2'b00, bird_pos} + {{5{vel_n[5]}}, vel_n};
        floor_hit = !by_raw[10] && (by_raw[9:0] >= {1'b0, YF});
        if (by_raw[10])     by_c = '0;
        else if (floor_hit) by_c = YF;
        else                by_c = by_raw[8:0];

        respawn   = (pipe_pos <= SPEED);
        pipe_n    = respawn ? SPAWN : (pipe_pos - SPEED);
        hole_n    = respawn ? (HMIN + {1'b0, lfsr}) : hole_pos;
        passed_n  = respawn ? 1'b0 : passed;

        pipe12    = {2'b00, pipe_n};
        by12      = {3'b000, by_c};
        hole12    = {3'b000, hole_n};
        pass_now  = !passed_n && (pipe12 + PW <= BX);
        x_ovl     = (pipe12 < BX + BSZ) && (pipe12 + PW > BX);
        hit       = x_ovl && ((by12 < hole12) || (by12 + BSZ > hole12 + HH));
        die       = hit | floor_hit;
    end

    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            bird_pos  <= Y0;
            hole_pos  <= HOLE_RST;
            pipe_pos  <= SPAWN;
            score     <= '0;
            vel       <= '0;
            flap_pend <= 1'b0;
            passed    <= 1'b0;
            dead_cnt  <= '0;
            lfsr      <= 8'h01;
            vs_q      <= 1'b0;
            btn_q     <= 1'b0;
        end else begin
            vs_q  <= v_sync;
            btn_q <= button;
            lfsr  <= {lfsr[6:0], lfsr_fb};

            case (st)
                IDLE: begin
                    if (btn_rise) begin
                        st        <= PLAY;
                        score     <= '0;
                        flap_pend <= 1'b1;
                    end
                end

                PLAY: begin
                    if (tick) begin
                        flap_pend <= 1'b0;
                        vel       <= vel_n;
                        bird_pos  <= by_c;
                        pipe_pos  <= pipe_n;
                        hole_pos  <= hole_n;
                        passed    <= passed_n | pass_now;
                        if (die) begin
                            st       <= DEAD;
                            dead_cnt <= '0;
                        end else if (pass_now && score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                    end else if (btn_rise) begin
                        flap_pend <= 1'b1;
                    end
                end

                DEAD: begin
                    flap_pend <= 1'b0;
                    if (btn_rise && dead_cnt == DC_MAX) begin
                        st       <= IDLE;
                        bird_pos <= Y0;
                        pipe_pos <= SPAWN;
                        hole_pos <= HOLE_RST;
                        vel      <= '0;
                        passed   <= 1'b0;
                    end else if (tick && dead_cnt != DC_MAX) begin
                        dead_cnt <= dead_cnt + DC_ONE;
                    end
                end

                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_physics_ctrl.sv
// Self-checking bench for game_physics_ctrl: a reference model pushes expected outputs per frame
// into a scoreboard; a second instance with a short pipe loop exercises score saturation.
module tb_game_physics_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic vs  [2];
    logic btn [2];

    always #5 clk = ~clk;

    logic [8:0] a_bird, a_hole, b_bird, b_hole;
    logic [9:0] a_pipe, b_pipe;
    logic [7:0] a_score, b_score;
    logic [1:0] a_state, b_state;
    logic [37:0] obs [2];

    assign obs[0] = {a_state, a_score, a_pipe, a_hole, a_bird};
    assign obs[1] = {b_state, b_score, b_pipe, b_hole, b_bird};

    game_physics_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .v_sync(vs[0]), .button(btn[0]),
        .bird_pos(a_bird), .hole_pos(a_hole), .pipe_pos(a_pipe), .score(a_score), .state(a_state)
    );

    game_physics_ctrl #(.PIPE_SPAWN(112), .PIPE_SPEED(4), .HOLE_H(400)) u_b (
        .clk(clk), .rst_n(rst_n), .v_sync(vs[1]), .button(btn[1]),
        .bird_pos(b_bird), .hole_pos(b_hole), .pipe_pos(b_pipe), .score(b_score), .state(b_state)
    );

    int total = 0;
    int bad   = 0;

    int spawn_c [2] = '{640, 112};
    int speed_c [2] = '{2, 4};
    int hh_c    [2] = '{100, 400};

    logic [7:0] lfsr_m;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_m <= 8'h01;
        else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};

    typedef struct {
        int st; int bird; int hole; int pipe; int score; int vel; int dead_cnt;
        bit flap_pend; bit passed;
    } mdl_t;
    mdl_t m [2];

    typedef struct {
        int          inst;
        logic [37:0] v;
    } exp_t;
    exp_t sb [$];

    function automatic logic [37:0] pk(int st, int sc, int pp, int hl, int bd);
        logic [1:0] s2 = 2'(st);
        logic [7:0] c8 = 8'(sc);
        logic [9:0] p10 = 10'(pp);
        logic [8:0] h9 = 9'(hl);
        logic [8:0] b9 = 9'(bd);
        return {s2, c8, p10, h9, b9};
    endfunction

    task automatic model_reset(int i);
        m[i].st = 0; m[i].bird = 236; m[i].hole = 190; m[i].pipe = spawn_c[i];
        m[i].score = 0; m[i].vel = 0; m[i].dead_cnt = 0; m[i].flap_pend = 0; m[i].passed = 0;
    endtask

    // p: button rise at this edge, t: frame tick at this edge
    task automatic model_step(int i, bit p, bit t);
        int v, by, hx;
        bit fl, pass, hit;
        case (m[i].st)
            0: if (p) begin m[i].st = 1; m[i].score = 0; m[i].flap_pend = 1; end
            1: begin
                if (t) begin
                    v  = (m[i].flap_pend || p) ? -6 : ((m[i].vel + 1 > 8) ? 8 : m[i].vel + 1);
                    by = m[i].bird + v;
                    fl = 0;
                    if (by < 0) by = 0;
                    else if (by >= 472) begin by = 472; fl = 1; end
                    if (m[i].pipe <= speed_c[i]) begin
                        m[i].pipe = spawn_c[i]; m[i].hole = 40 + int'(lfsr_m); m[i].passed = 0;
                    end else m[i].pipe = m[i].pipe - speed_c[i];
                    pass = !m[i].passed && (m[i].pipe + 40 <= 100);
                    hx   = (m[i].pipe < 108 && m[i].pipe + 40 > 100) ? 1 : 0;
                    hit  = (hx == 1) && (by < m[i].hole || by + 8 > m[i].hole + hh_c[i]);
                    m[i].vel = v; m[i].bird = by; m[i].flap_pend = 0;
                    if (pass) m[i].passed = 1;
                    if (hit || fl) begin m[i].st = 2; m[i].dead_cnt = 0; end
                    else if (pass && m[i].score < 255) m[i].score++;
                end else if (p) m[i].flap_pend = 1;
            end
            default: begin
                m[i].flap_pend = 0;
                if (p && m[i].dead_cnt == 30) begin
                    m[i].st = 0; m[i].bird = 236; m[i].pipe = spawn_c[i];
                    m[i].vel = 0; m[i].hole = 190; m[i].passed = 0;
                end else if (t && m[i].dead_cnt < 30) m[i].dead_cnt++;
            end
        endcase
    endtask

    // One two-cycle frame slot: drive inputs, predict, then compare once outputs settle.
    task automatic frame(int i, bit p, bit t, string tag);
        exp_t e;
        @(negedge clk);
        vs[i] = t; btn[i] = p;
        model_step(i, p, t);
        e.inst = i;
        e.v = pk(m[i].st, m[i].score, m[i].pipe, m[i].hole, m[i].bird);
        sb.push_back(e);
        @(negedge clk);
        vs[i] = 1'b0; btn[i] = 1'b0;
        e = sb.pop_front();
        total++;
        if (obs[e.inst] !== e.v) begin
            bad++;
            $display("FAIL %s inst=%0d got st=%0d sc=%0d pipe=%0d hole=%0d bird=%0d want st=%0d sc=%0d pipe=%0d hole=%0d bird=%0d",
                     tag, e.inst, obs[e.inst][37:36], obs[e.inst][35:28], obs[e.inst][27:18],
                     obs[e.inst][17:9], obs[e.inst][8:0], e.v[37:36], e.v[35:28], e.v[27:18],
                     e.v[17:9], e.v[8:0]);
        end
    endtask

    task automatic test_reset;
        logic [37:0] ra, rb;
        ra = pk(0, 0, 640, 190, 236);
        rb = pk(0, 0, 112, 190, 236);
        total++;
        if (obs[0] !== ra) begin bad++; $display("FAIL reset_a got=%h want=%h", obs[0], ra); end
        total++;
        if (obs[1] !== rb) begin bad++; $display("FAIL reset_b got=%h want=%h", obs[1], rb); end
    endtask

    task automatic test_idle;
        for (int k = 0; k < 5; k++) frame(0, 1'b0, 1'b1, "idle_tick");
        total++;
        if (a_state !== 2'b00 || a_bird !== 9'd236 || a_pipe !== 10'd640 || a_score !== 8'd0) begin
            bad++;
            $display("FAIL idle_frozen got st=%0d bird=%0d pipe=%0d score=%0d want 0/236/640/0",
                     a_state, a_bird, a_pipe, a_score);
        end
    endtask

    task automatic test_start;
        int want [3] = '{225, 221, 218};
        frame(0, 1'b1, 1'b0, "start_press");
        total++;
        if (a_state !== 2'b01) begin bad++; $display("FAIL start_state got=%0d want=1", a_state); end
        frame(0, 1'b0, 1'b1, "first_tick");
        total++;
        if (a_bird !== 9'd230 || a_pipe !== 10'd638) begin
            bad++; $display("FAIL first_tick got bird=%0d pipe=%0d want 230/638", a_bird, a_pipe);
        end
        for (int k = 0; k < 3; k++) begin
            frame(0, 1'b0, 1'b1, "gravity");
            total++;
            if (a_bird !== 9'(want[k])) begin
                bad++; $display("FAIL gravity_%0d got=%0d want=%0d", k, a_bird, want[k]);
            end
        end
    endtask

    task automatic test_floor;
        int n = 0;
        while (a_state != 2'b10 && n < 100) begin frame(0, 1'b0, 1'b1, "fall"); n++; end
        total++;
        if (a_state !== 2'b10 || a_bird !== 9'd472 || a_score !== 8'd0) begin
            bad++;
            $display("FAIL floor_death got st=%0d bird=%0d score=%0d want 2/472/0 (ticks=%0d)",
                     a_state, a_bird, a_score, n);
        end
    endtask

    task automatic recover;
        for (int k = 0; k < 31; k++) frame(0, 1'b0, 1'b1, "dead_wait");
        frame(0, 1'b1, 1'b0, "restart");
        total++;
        if (a_state !== 2'b00) begin bad++; $display("FAIL recover_state got=%0d want=0", a_state); end
    endtask

    task automatic test_pass;
        int n = 0, respawns = 0;
        logic [7:0] prev;
        frame(0, 1'b1, 1'b0, "pass_go");
        prev = a_score;
        while (a_score != 8'd2 && n < 1500) begin
            frame(0, m[0].bird > m[0].hole + 40, 1'b1, "fly");
            n++;
            if (a_score != prev) begin
                total++;
                if (a_score !== prev + 8'd1) begin
                    bad++; $display("FAIL pass_step got=%0d want=%0d", a_score, prev + 8'd1);
                end
                prev = a_score;
            end
            if (a_pipe == 10'd640) begin
                respawns++;
                total++;
                if (a_hole < 9'd40 || a_hole > 9'd295) begin
                    bad++; $display("FAIL hole_range got=%0d want 40..295", a_hole);
                end
            end
        end
        total++;
        if (a_score !== 8'd2 || a_state !== 2'b01 || respawns != 1) begin
            bad++;
            $display("FAIL pass_done got score=%0d st=%0d respawns=%0d want 2/1/1", a_score, a_state, respawns);
        end
    endtask

    task automatic test_hit;
        int n = 0;
        while (a_state != 2'b10 && n < 800) begin
            frame(0, m[0].bird > m[0].hole - 40, 1'b1, "fly_high");
            n++;
        end
        total++;
        if (a_state !== 2'b10 || a_pipe !== 10'd106 || a_bird >= a_hole || a_score !== 8'd2) begin
            bad++;
            $display("FAIL hit_death got st=%0d pipe=%0d bird=%0d hole=%0d score=%0d want st=2 pipe=106 bird<hole score=2",
                     a_state, a_pipe, a_bird, a_hole, a_score);
        end
    endtask

    task automatic test_dead_restart;
        frame(0, 1'b1, 1'b0, "early_press");
        total++;
        if (a_state !== 2'b10) begin bad++; $display("FAIL early_press got=%0d want=2", a_state); end
        for (int k = 0; k < 29; k++) frame(0, 1'b0, 1'b1, "dead_tick");
        frame(0, 1'b1, 1'b0, "press_at_29");
        total++;
        if (a_state !== 2'b10) begin bad++; $display("FAIL press_at_29 got=%0d want=2", a_state); end
        for (int k = 0; k < 3; k++) frame(0, 1'b0, 1'b1, "dead_sat");
        frame(0, 1'b1, 1'b0, "press_at_30");
        total++;
        if (a_state !== 2'b00 || a_bird !== 9'd236 || a_pipe !== 10'd640 || a_hole !== 9'd190 || a_score !== 8'd2) begin
            bad++;
            $display("FAIL restart got st=%0d bird=%0d pipe=%0d hole=%0d score=%0d want 0/236/640/190/2",
                     a_state, a_bird, a_pipe, a_hole, a_score);
        end
        frame(0, 1'b1, 1'b0, "replay");
        total++;
        if (a_state !== 2'b01 || a_score !== 8'd0) begin
            bad++; $display("FAIL replay got st=%0d score=%0d want 1/0", a_state, a_score);
        end
    endtask

    task automatic test_mid_reset;
        logic [37:0] ra, rb;
        for (int k = 0; k < 5; k++) frame(0, m[0].bird > m[0].hole + 40, 1'b1, "pre_reset");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        ra = pk(0, 0, 640, 190, 236);
        rb = pk(0, 0, 112, 190, 236);
        total++;
        if (obs[0] !== ra) begin bad++; $display("FAIL mid_reset_a got=%h want=%h", obs[0], ra); end
        total++;
        if (obs[1] !== rb) begin bad++; $display("FAIL mid_reset_b got=%h want=%h", obs[1], rb); end
        model_reset(0);
        model_reset(1);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saturate;
        frame(1, 1'b1, 1'b0, "sat_go");
        for (int n = 0; n < 7220; n++) frame(1, m[1].bird > 360, 1'b1, "sat_fly");
        total++;
        if (b_score !== 8'd255 || b_state !== 2'b01) begin
            bad++; $display("FAIL saturate got score=%0d st=%0d want 255/1", b_score, b_state);
        end
    endtask

    initial begin
        vs[0] = 1'b0; vs[1] = 1'b0; btn[0] = 1'b0; btn[1] = 1'b0;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_idle;
        test_start;
        test_floor;
        recover;
        test_pass;
        test_hit;
        test_dead_restart;
        test_mid_reset;
        test_saturate;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
